// File: rtl/nv_nvdla_rubik_csb_reg_master.sv
// rtl/nv_nvdla_rubik_csb_reg_master.sv - CSB register initiator for RUBIK: one request at a time, decoded to single/dual register groups.
// Optional: define NVDLA_RBK_CSB_ERR_EN to report invalid-group accesses in resp_pd[32].
module nv_nvdla_rubik_csb_reg_master #(
    parameter logic [3:0] GRP_SINGLE = 4'h0,
    parameter logic [3:0] GRP_DUAL0  = 4'h1,
    parameter logic [3:0] GRP_DUAL1  = 4'h2
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        csb2rbk_req_pvld,
    output logic        csb2rbk_req_prdy,
    input  logic [62:0] csb2rbk_req_pd,
    output logic        rbk2csb_resp_valid,
    output logic [33:0] rbk2csb_resp_pd,
    output logic [11:0] reg_offset,
    output logic [31:0] reg_wr_data,
    output logic        s_reg_wr_en,
    output logic        d0_reg_wr_en,
    output logic        d1_reg_wr_en,
    input  logic [31:0] s_reg_rd_data,
    input  logic [31:0] d0_reg_rd_data,
    input  logic [31:0] d1_reg_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  grp_q;
    logic        write_q;
    logic        nposted_q;
    logic [11:0] reg_offset_q;
    logic [31:0] reg_wr_data_q;
    logic [33:0] resp_pd_q, resp_pd_d;

    logic        accept;
    logic        sel_s, sel_d0, sel_d1, grp_valid;
    logic [31:0] rd_sel;
    logic        err_bit;
    logic        unused_pd_bits;

    assign unused_pd_bits = ^{csb2rbk_req_pd[62:56], csb2rbk_req_pd[21:14]};

    assign accept = csb2rbk_req_pvld && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sel_s     = (grp_q == GRP_SINGLE);
    assign sel_d0    = (grp_q == GRP_DUAL0);
    assign sel_d1    = (grp_q == GRP_DUAL1);
    assign grp_valid = sel_s || sel_d0 || sel_d1;

    always_comb begin
        rd_sel = 32'h0;
        if (sel_s)       rd_sel = s_reg_rd_data;
        else if (sel_d0) rd_sel = d0_reg_rd_data;
        else if (sel_d1) rd_sel = d1_reg_rd_data;
    end

`ifdef NVDLA_RBK_CSB_ERR_EN
    assign err_bit = !grp_valid;
`else
    assign err_bit = 1'b0;
`endif

    // Write acks carry zero data; reads sample the group's combinational read port.
    always_comb begin
        resp_pd_d = resp_pd_q;
        if (state_q == ACCESS) begin
            resp_pd_d = {write_q, err_bit, (write_q ? 32'h0 : rd_sel)};
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q       <= IDLE;
            grp_q         <= 4'h0;
            write_q       <= 1'b0;
            nposted_q     <= 1'b0;
            reg_offset_q  <= 12'h0;
            reg_wr_data_q <= 32'h0;
            resp_pd_q     <= 34'h0;
        end else begin
            state_q   <= state_d;
            resp_pd_q <= resp_pd_d;
            if (accept) begin
                grp_q         <= csb2rbk_req_pd[13:10];
                write_q       <= csb2rbk_req_pd[54];
                nposted_q     <= csb2rbk_req_pd[55];
                reg_offset_q  <= {csb2rbk_req_pd[9:0], 2'b00};
                reg_wr_data_q <= csb2rbk_req_pd[53:22];
            end
        end
    end

    assign csb2rbk_req_prdy   = (state_q == IDLE);
    assign reg_offset         = reg_offset_q;
    assign reg_wr_data        = reg_wr_data_q;
    assign s_reg_wr_en        = (state_q == ACCESS) && write_q && sel_s;
    assign d0_reg_wr_en       = (state_q == ACCESS) && write_q && sel_d0;
    assign d1_reg_wr_en       = (state_q == ACCESS) && write_q && sel_d1;
    assign rbk2csb_resp_valid = (state_q == RESP) && (!write_q || nposted_q);
    assign rbk2csb_resp_pd    = resp_pd_q;

endmodule

// File: tb/tb_nv_nvdla_rubik_csb_reg_master.sv
// tb/tb_nv_nvdla_rubik_csb_reg_master.sv - scoreboard bench for the RUBIK CSB register initiator.
module tb_nv_nvdla_rubik_csb_reg_master;

`ifdef NVDLA_RBK_CSB_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pvld = 1'b0;
    logic        prdy;
    logic [62:0] pd = '0;
    logic        resp_valid;
    logic [33:0] resp_pd;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        s_wr_en, d0_wr_en, d1_wr_en;
    logic [31:0] s_rd  = 32'h0001_0001;
    logic [31:0] d0_rd = 32'hCAFE_0123;
    logic [31:0] d1_rd = 32'h1234_5678;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { logic [33:0] pd; int cyc; } resp_t;
    typedef struct { logic [2:0] strb; logic [11:0] off; logic [31:0] wd; int cyc; } strb_t;
    resp_t resp_q[$];
    strb_t strb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nv_nvdla_rubik_csb_reg_master dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rstn    (rstn),
        .csb2rbk_req_pvld   (pvld),
        .csb2rbk_req_prdy   (prdy),
        .csb2rbk_req_pd     (pd),
        .rbk2csb_resp_valid (resp_valid),
        .rbk2csb_resp_pd    (resp_pd),
        .reg_offset         (reg_offset),
        .reg_wr_data        (reg_wr_data),
        .s_reg_wr_en        (s_wr_en),
        .d0_reg_wr_en       (d0_wr_en),
        .d1_reg_wr_en       (d1_wr_en),
        .s_reg_rd_data      (s_rd),
        .d0_reg_rd_data     (d0_rd),
        .d1_reg_rd_data     (d1_rd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        resp_t e;
        if (rstn && resp_valid) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got pd=%h at cycle %0d expected none", resp_pd, cyc);
            end else begin
                e = resp_q.pop_front();
                if (resp_pd !== e.pd || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp: got pd=%h cycle %0d expected pd=%h cycle %0d", resp_pd, cyc, e.pd, e.cyc);
                end
            end
        end
    end

    // Write-strobe monitor
    always @(negedge clk) begin
        strb_t e;
        if (rstn && (s_wr_en || d0_wr_en || d1_wr_en)) begin
            checks++;
            if (strb_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got strb=%b at cycle %0d expected none", {s_wr_en, d0_wr_en, d1_wr_en}, cyc);
            end else begin
                e = strb_q.pop_front();
                if ({s_wr_en, d0_wr_en, d1_wr_en} !== e.strb || reg_offset !== e.off ||
                    reg_wr_data !== e.wd || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe: got strb=%b off=%h wd=%h cycle %0d expected strb=%b off=%h wd=%h cycle %0d",
                             {s_wr_en, d0_wr_en, d1_wr_en}, reg_offset, reg_wr_data, cyc,
                             e.strb, e.off, e.wd, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [21:0] addr, input logic [31:0] wd, input logic wr, input logic np,
                         input logic [2:0] es, input logic [11:0] eo,
                         input logic er, input logic [33:0] ep, input logic keep);
        int n = 0;
        @(negedge clk);
        while (!prdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!prdy) begin
            check("prdy_timeout", {63'h0, prdy}, 64'h1);
            return;
        end
        pd   = {7'h0, np, wr, wd, addr};
        pvld = 1'b1;
        if (es != 3'b000) strb_q.push_back('{es, eo, wd, cyc + 1});
        if (er) resp_q.push_back('{ep, cyc + 2});
        if (!keep) begin
            @(negedge clk);
            pvld = 1'b0;
        end
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_prdy",    {63'h0, prdy}, 64'h1);
        check("rst_valid",   {63'h0, resp_valid}, 64'h0);
        check("rst_pd",      {30'h0, resp_pd}, 64'h0);
        check("rst_offset",  {52'h0, reg_offset}, 64'h0);
        check("rst_wdata",   {32'h0, reg_wr_data}, 64'h0);
        check("rst_wr_en",   {61'h0, s_wr_en, d0_wr_en, d1_wr_en}, 64'h0);
        rstn = 1'b1;

        // Posted single write: strobe, no response, prdy low two cycles
        issue(22'h4001, 32'h0000_0001, 1'b1, 1'b0, 3'b100, 12'h004, 1'b0, 34'h0, 1'b0);
        check("prdy_low_1", {63'h0, prdy}, 64'h0);
        @(negedge clk);
        check("prdy_low_2", {63'h0, prdy}, 64'h0);
        @(negedge clk);
        check("prdy_back",  {63'h0, prdy}, 64'h1);

        issue(22'h4001, 32'h0, 1'b0, 1'b0, 3'b000, 12'h0, 1'b1, 34'h0_0001_0001, 1'b0);
        issue(22'h0802, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b001, 12'h008, 1'b1, 34'h2_0000_0000, 1'b0);
        issue(22'h0C00, 32'h0, 1'b0, 1'b0, 3'b000, 12'h0, 1'b1, {1'b0, ERR, 32'h0}, 1'b0);
        issue(22'h0405, 32'h0, 1'b0, 1'b0, 3'b000, 12'h0, 1'b1, 34'h0_CAFE_0123, 1'b0);
        issue(22'h0C04, 32'h5555_AAAA, 1'b1, 1'b1, 3'b000, 12'h0, 1'b1, {1'b1, ERR, 32'h0}, 1'b0);
        issue(22'h0C08, 32'h7777_7777, 1'b1, 1'b0, 3'b000, 12'h0, 1'b0, 34'h0, 1'b0);
        check("offset_hold", {52'h0, reg_offset}, 64'h020);

        // Back-to-back with pvld held high
        issue(22'h0410, 32'h0000_0005, 1'b1, 1'b1, 3'b010, 12'h040, 1'b1, 34'h2_0000_0000, 1'b1);
        issue(22'h0801, 32'h0, 1'b0, 1'b0, 3'b000, 12'h0, 1'b1, 34'h0_1234_5678, 1'b1);
        issue(22'h0003, 32'h0, 1'b0, 1'b0, 3'b000, 12'h0, 1'b1, 34'h0_0001_0001, 1'b0);

        // Reset during ACCESS of a read
        @(negedge clk);
        while (!prdy) @(negedge clk);
        pd   = {7'h0, 1'b0, 1'b0, 32'h0, 22'h0433};
        pvld = 1'b1;
        @(negedge clk);
        pvld = 1'b0;
        check("access_offset", {52'h0, reg_offset}, 64'h0CC);
        rstn = 1'b0;
        #1;
        check("midrst_prdy",   {63'h0, prdy}, 64'h1);
        check("midrst_valid",  {63'h0, resp_valid}, 64'h0);
        check("midrst_pd",     {30'h0, resp_pd}, 64'h0);
        check("midrst_offset", {52'h0, reg_offset}, 64'h0);
        check("midrst_wdata",  {32'h0, reg_wr_data}, 64'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        issue(22'h0800, 32'h0, 1'b0, 1'b0, 3'b000, 12'h0, 1'b1, 34'h0_1234_5678, 1'b0);

        repeat (5) @(negedge clk);
        check("resp_q_drained", 64'(resp_q.size()), 64'h0);
        check("strb_q_drained", 64'(strb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
